// File: rtl/seq_ring_fsm_if.sv
// Control/status bundle between a sequencer client and seq_ring_fsm.
// No storage: pure wiring, zero latency.
// No backpressure: enable acts as the only advance qualifier.
interface seq_ring_fsm_if #(
    parameter int ST_W = 2,
    parameter int Y_W  = 3
);
    logic            enable;
    logic            sync_clr;
    logic            control;
    logic [Y_W-1:0]  y;
    logic [ST_W-1:0] state;
    logic            wrap;

    // Client side: drives the qualifiers, observes the sequencer outputs.
    modport master (
        output enable, sync_clr, control,
        input  y, state, wrap
    );

    // Sequencer side.
    modport slave (
        input  enable, sync_clr, control,
        output y, state, wrap
    );
endinterface

// File: rtl/seq_ring_fsm.sv
// Ring sequencer stepping through NUM_ST states with one programmable branch
// state (skip on control=0); optional per-state dwell via SEQ_RING_DWELL_EN.
// Latency: one cycle, all outputs registered; enable=0 holds all state.
module seq_ring_fsm #(
    parameter int NUM_ST    = 4,
    parameter int ST_W      = 2,
    parameter int Y_W       = 3,
    parameter int BRANCH_ST = 1,
    parameter int DWELL     = 1
) (
    input logic           clock,
    input logic           reset,
    seq_ring_fsm_if.slave bus
);

    if (NUM_ST < 2 || NUM_ST > 16 || NUM_ST > (2 ** ST_W) ||
        BRANCH_ST < 0 || BRANCH_ST >= NUM_ST || DWELL < 1 || DWELL > 255) begin : g_bad_param
        $error("seq_ring_fsm: parameter out of range");
    end

    localparam logic [ST_W-1:0] ST_IDLE = '0;
    localparam logic [Y_W-1:0]  Y_IDLE  = Y_W'(1);

    logic [ST_W-1:0] st_q;
    logic [ST_W-1:0] st_d;
    logic [Y_W-1:0]  y_q;
    logic [Y_W-1:0]  y_d;
    logic            wrap_q;
    logic            wrap_d;
    logic            illegal;
    logic            adv;
    int              cand;
    int              nxt;

    // Next-state candidate: +1 normally, +2 from the branch state when control is low.
    always_comb begin
        illegal = (int'(st_q) >= NUM_ST);
        cand    = int'(st_q) + (((int'(st_q) == BRANCH_ST) && !bus.control) ? 2 : 1);
        wrap_d  = (cand >= NUM_ST);
        nxt     = wrap_d ? (cand - NUM_ST) : cand;
        st_d    = ST_W'(nxt);
        y_d     = Y_W'(nxt + 1);
    end

`ifdef SEQ_RING_DWELL_EN
    localparam int CNT_W = $clog2(DWELL + 1);

    logic [CNT_W-1:0] cnt_q;

    // Advance only on the last enabled cycle of the dwell window.
    always_comb begin
        adv = bus.enable && (int'(cnt_q) == DWELL - 1);
    end

    // Dwell counter: counts enabled cycles in the current state, clears on advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.sync_clr || illegal) begin
            cnt_q <= '0;
        end else if (bus.enable) begin
            cnt_q <= adv ? '0 : cnt_q + CNT_W'(1);
        end
    end
`else
    // Without dwell every enabled cycle is an advance step.
    always_comb begin
        adv = bus.enable;
    end
`endif

    // State/output registers: reset > sync_clr > illegal recovery > advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q   <= ST_IDLE;
            y_q    <= Y_IDLE;
            wrap_q <= 1'b0;
        end else if (bus.sync_clr || illegal) begin
            st_q   <= ST_IDLE;
            y_q    <= Y_IDLE;
            wrap_q <= 1'b0;
        end else if (adv) begin
            st_q   <= st_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.state = st_q;
    assign bus.y     = y_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: doc/seq_ring_fsm.md
# seq_ring_fsm

Parametrised ring sequencer: a NUM_ST-state controller that steps through its states in order and drives a per-state output code. One programmable branch state uses `control` either to advance or to skip a state. It adds an enable, a synchronous clear, a wrap-around pulse and illegal-state recovery. It serves as the generic sequencing core for control paths that previously used fixed four-state case machines.

## Interface
- `NUM_ST`, 4: number of legal states, 2..16.
- `ST_W`, 2: state register width; NUM_ST <= 2**ST_W.
- `Y_W`, 3: output code width.
- `BRANCH_ST`, 1: index of the branch state, 0..NUM_ST-1.
- `DWELL`, 1: enabled cycles spent in each state, 1..255; used only with SEQ_RING_DWELL_EN.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  advance qualifier; when low, all state is held.
- `sync_clr`  in  1  synchronous return to state 0.
- `control`  in  1  branch select, sampled only in BRANCH_ST.
- `y`  out  Y_W  registered output code of the current state.
- `state`  out  ST_W  registered current state index.
- `wrap`  out  1  registered one-cycle pulse on ring wrap-around.

## Operation
- Reset (`reset`=0, asynchronous): `state`=0, `y`=1, `wrap`=0, dwell counter=0.
- Priority at each edge: reset > `sync_clr` > illegal recovery > `enable`.
- `sync_clr`=1: `state`=0, `y`=1, `wrap`=0 and the dwell counter clears, regardless of `enable`.
- Advance step from state S when S is not BRANCH_ST: the candidate is S+1.
- Advance step from BRANCH_ST:
  - `control`=1 gives a candidate of S+1.
  - `control`=0 gives a candidate of S+2 (skip).
- Next state = candidate mod NUM_ST. `wrap`=1 for exactly that cycle when candidate >= NUM_ST; otherwise `wrap`=0.
- `y` = (next state + 1) mod 2**Y_W. It is registered on the same edge as `state`, so `y` always equals `state`+1.
- Illegal state (`state` >= NUM_ST; reachable only by upset): the next edge forces `state`=0 and `y`=1. This ignores `enable` and dwell, and `wrap`=0.
- `enable`=0: `state`, `y` and the dwell counter hold; `wrap`=0.
- Degenerate case NUM_ST=2, BRANCH_ST=0, `control`=0: the candidate is 2, so the next state is 0 (self-loop) with `wrap`=1.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- One-cycle latency: `enable`/`control` sampled at edge k are reflected in `state`/`y`/`wrap` after edge k.
- `wrap` is high for exactly one cycle per wrapping transition. Back-to-back wraps give back-to-back pulses.
- Reset deassertion is taken synchronously by the surrounding reset synchroniser. The first advance can occur at the first edge after deassertion.
- Reset asserted mid-sequence forces reset values immediately, without waiting for a clock edge.

## Configuration
- `SEQ_RING_DWELL_EN` defined:
  - A dwell counter of clog2(DWELL+1) bits counts enabled cycles in the current state.
  - An advance step is taken only when `enable`=1 and counter == DWELL-1; the counter then clears.
  - `control` is sampled only on that advancing cycle.
  - With DWELL=1, behaviour equals the undefined case.
- `SEQ_RING_DWELL_EN` undefined: no counter is built, DWELL is ignored, and every enabled cycle takes an advance step.

## Test plan
- Defaults (NUM_ST=4, BRANCH_ST=1), `control`=1, `enable`=1 after reset: `state` 0,1,2,3,0; `y` 1,2,3,4,1; `wrap`=1 only on the 3->0 transition.
- Defaults, `control`=0: `state` 0,1,3,0; `y` 1,2,4,1; no visit to state 2; `wrap` pulses on 3->0.
- NUM_ST=4, BRANCH_ST=3, `control`=0: from 3 the candidate is 5, giving `state` 1, `y`=2, `wrap`=1.
- `enable` toggled 1,0,0,1 from state 1: `state` holds at 2 for two cycles, then goes to 3; `wrap` stays 0 while held.
- `sync_clr` and `reset` checks:
  - `sync_clr`=1 with `enable`=1 in state 2: `state`=0, `y`=1, `wrap`=0 next edge.
  - Async `reset` pulse mid-cycle: outputs go to 0/1/0 before the next edge.
- With `SEQ_RING_DWELL_EN` defined, DWELL=3, `control`=1: each state is held 3 enabled cycles (`y` 1,1,1,2,2,2,...). Forcing `state`=3 with NUM_ST=3 recovers to 0 in one edge.
